// File: rtl/control_sequencer.sv
// Purpose: instruction phase sequencer (fetch/decode/execute/mem/writeback) with pause, halt and illegal-ID handling.
// Latency: 4 cycles per non-memory instruction, 4+N for memory instructions (N = MEM cycles until mem_ready).
// Backpressure: mem_ready stalls in MEM with no timeout; a rising edge on enter releases PAUSE.
module control_sequencer #(
  parameter int                  ID_WIDTH     = 7,
  parameter logic [ID_WIDTH-1:0] MEM_FIRST_ID = ID_WIDTH'(7'h30),
  parameter logic [ID_WIDTH-1:0] MEM_LAST_ID  = ID_WIDTH'(7'h39)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] id,
  input  logic                enter,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                ir_load,
  output logic                exec_en,
  output logic                mem_req,
  output logic                wb_en,
  output logic                pc_update,
  output logic                halted,
  output logic                waiting,
  output logic                illegal
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PAUSE     = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  // Special instruction IDs recognised in DECODE.
  localparam logic [ID_WIDTH-1:0] ID_PAUSE  = ID_WIDTH'(70);
  localparam logic [ID_WIDTH-1:0] ID_INPUT  = ID_WIDTH'(71);
  localparam logic [ID_WIDTH-1:0] ID_HLT    = ID_WIDTH'(75);
  localparam logic [ID_WIDTH-1:0] ID_RST    = ID_WIDTH'(100);
  localparam logic [ID_WIDTH-1:0] ID_ILL_LO = ID_WIDTH'(7'h7a);
  localparam logic [ID_WIDTH-1:0] ILL_SPAN  = ID_WIDTH'(6);

  // Illegal window 7a..7f tested as an offset so no comparison is constant at the top of the ID range.
  function automatic logic is_illegal(input logic [ID_WIDTH-1:0] v);
    logic [ID_WIDTH-1:0] off;
    off = v - ID_ILL_LO;
    return off < ILL_SPAN;
  endfunction

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                enter_prev_q, enter_prev_d;
  logic                enter_edge;
  logic                id_mem_q;
  logic                id_ill_q;

  assign enter_edge = enter & ~enter_prev_q;
  assign id_mem_q   = (id_q >= MEM_FIRST_ID) && (id_q <= MEM_LAST_ID);
  assign id_ill_q   = is_illegal(id_q);

  // Next-state selection; the ID is captured in DECODE and later phases consult only the captured copy.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    enter_prev_d = enter;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        id_d = id;
        if (id == ID_HLT)                         state_d = ST_HALT;
        else if ((id == ID_PAUSE) || (id == ID_INPUT)) state_d = ST_PAUSE;
        else if (id == ID_RST)                    state_d = ST_RESET;
        else if (is_illegal(id))                  state_d = ST_WRITEBACK;
        else                                      state_d = ST_EXECUTE;
      end
      ST_EXECUTE:   state_d = id_mem_q ? ST_MEM : ST_WRITEBACK;
      ST_MEM:       state_d = mem_ready ? ST_WRITEBACK : ST_MEM;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_PAUSE:     state_d = enter_edge ? ST_EXECUTE : ST_PAUSE;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // State register with synchronous reset taking priority over every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RESET;
      id_q         <= '0;
      enter_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      enter_prev_q <= enter_prev_d;
    end
  end

  // Strobes decode straight from the state flop (and the captured illegal bit), so they change only at the clock edge.
  assign state     = state_q;
  assign ir_load   = (state_q == ST_FETCH);
  assign exec_en   = (state_q == ST_EXECUTE);
  assign mem_req   = (state_q == ST_MEM);
  assign wb_en     = (state_q == ST_WRITEBACK) && !id_ill_q;
  assign pc_update = (state_q == ST_WRITEBACK);
  assign halted    = (state_q == ST_HALT);
  assign waiting   = (state_q == ST_PAUSE);
  assign illegal   = (state_q == ST_WRITEBACK) && id_ill_q;

endmodule
